// File: rtl/axis_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// axis_pkg : shared encodings and defaults for the AXIS arbiters
// Rev 1.0
// ------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DEFAULT_DW = 128;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick : combinational round-robin pick, scanning upward from last+1
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick #(
  parameter  int NUM_IN = 4,
  localparam int IW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IW-1:0]     i_last_grant,
  output logic [IW-1:0]     o_winner,
  output logic              o_found
);

  logic [IW:0] w_idx;

  // Scan from the far end so the nearest requester after last_grant wins.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int i = NUM_IN; i >= 1; i--) begin
      w_idx = {1'b0, i_last_grant} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(NUM_IN)) begin
        w_idx = w_idx - (IW+1)'(NUM_IN);
      end
      if (i_req[w_idx[IW-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_idx[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// axis_packet_arbiter : packet-granular round-robin AXI-Stream arbiter
// Optional counters: define AXIS_PKT_ARB_STATS_EN.   Rev 1.0
// ------------------------------------------------------------------
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter  int DW     = AXIS_DEFAULT_DW,
  parameter  int NUM_IN = 4,
  localparam int IW     = $clog2(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_IN*DW-1:0]   s_axis_tdata,
  input  logic [NUM_IN*DW/8-1:0] s_axis_tkeep,
  input  logic [NUM_IN-1:0]      s_axis_tlast,
  input  logic [NUM_IN-1:0]      s_axis_tvalid,
  output logic [NUM_IN-1:0]      s_axis_tready,
  output logic [DW-1:0]          m_axis_tdata,
  output logic [DW/8-1:0]        m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [IW-1:0]          m_axis_tid,
  output logic                   busy
`ifdef AXIS_PKT_ARB_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]   pkt_count,
  output logic [31:0]            stall_count
`endif
);

  arb_state_e      r_state;
  arb_state_e      w_next;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   w_winner;
  logic            w_found;
  logic            w_done;

  rr_pick #(
    .NUM_IN(NUM_IN)
  ) u_rr_pick (
    .i_req       (s_axis_tvalid),
    .i_last_grant(r_last_grant),
    .o_winner    (w_winner),
    .o_found     (w_found)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(NUM_IN-1);
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_winner;
      end
      if (w_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Outputs are gated by state so an async reset silences them at once.
  always_comb begin
    w_next        = r_state;
    w_done        = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    m_axis_tid    = '0;
    busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next = S_LOCKED;
        end
      end
      S_LOCKED: begin
        m_axis_tdata           = s_axis_tdata[r_grant*DW +: DW];
        m_axis_tkeep           = s_axis_tkeep[r_grant*(DW/8) +: DW/8];
        m_axis_tlast           = s_axis_tlast[r_grant];
        m_axis_tvalid          = s_axis_tvalid[r_grant];
        s_axis_tready[r_grant] = m_axis_tready;
        m_axis_tid             = r_grant;
        busy                   = 1'b1;
        w_done = s_axis_tvalid[r_grant] & m_axis_tready & s_axis_tlast[r_grant];
        if (w_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef AXIS_PKT_ARB_STATS_EN
  logic [31:0] r_pkt_count [NUM_IN];
  logic [31:0] r_stall_count;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_pkt_cnt
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_pkt_count[k] <= '0;
      end else if (w_done && r_grant == IW'(k)) begin
        r_pkt_count[k] <= r_pkt_count[k] + 32'd1;
      end
    end
    assign pkt_count[k*32 +: 32] = r_pkt_count[k];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && r_stall_count != 32'hFFFF_FFFF) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end
  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_axis_packet_arbiter : scoreboard bench for axis_packet_arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_axis_packet_arbiter;

  localparam int DW = 128;
  localparam int N  = 4;
  localparam int KW = DW/8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [1:0]    id;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N*DW-1:0] s_axis_tdata = '0;
  logic [N*KW-1:0] s_axis_tkeep = '0;
  logic [N-1:0]    s_axis_tlast = '0;
  logic [N-1:0]    s_axis_tvalid = '0;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [1:0]      m_axis_tid;
  logic            busy;
`ifdef AXIS_PKT_ARB_STATS_EN
  logic [N*32-1:0] pkt_count;
  logic [31:0]     stall_count;
`endif

  beat_t src_q [N][$];
  beat_t exp_q [$];
  logic  src_hold [N];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.DW(DW), .NUM_IN(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tid   (m_axis_tid),
    .busy         (busy)
`ifdef AXIS_PKT_ARB_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      src_hold[k] = 1'b0;
    end
    exp_q.delete();
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic add_pkt(input int k, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == nbeats-1);
      b.keep = b.last ? KW'($urandom_range(1, 65535)) : '1;
      b.id   = 2'(k);
      src_q[k].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // One cycle: drive sources at negedge, then score any handshake.
  task automatic step();
    beat_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && !src_hold[k]) begin
        s_axis_tvalid[k]         = 1'b1;
        s_axis_tdata[k*DW +: DW] = src_q[k][0].data;
        s_axis_tkeep[k*KW +: KW] = src_q[k][0].keep;
        s_axis_tlast[k]          = src_q[k][0].last;
      end else begin
        s_axis_tvalid[k] = 1'b0;
        s_axis_tlast[k]  = 1'b0;
      end
    end
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got beat id=%0d, required no beat", m_axis_tid);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
            m_axis_tlast !== e.last || m_axis_tid !== e.id) begin
          n_fail++;
          $display("FAIL sb_beat: got id=%0d last=%b keep=%h data=%h, required id=%0d last=%b keep=%h data=%h",
                   m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, e.id, e.last, e.keep, e.data);
        end
        if (src_q[m_axis_tid].size() > 0) void'(src_q[m_axis_tid].pop_front());
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0 || busy !== 1'b0 ||
        m_axis_tid !== 2'd0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ready=%b busy=%b tid=%0d, required all 0",
               m_axis_tvalid, s_axis_tready, busy, m_axis_tid);
    end
  endtask

  task automatic test_single_source();
    do_reset();
    add_pkt(2, 3);
    step();
    n_tests++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arb_latency: got valid=%b busy=%b, required 0 0", m_axis_tvalid, busy);
    end
    step();
    n_tests++;
    if (m_axis_tid !== 2'd2 || busy !== 1'b1 || s_axis_tready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got tid=%0d busy=%b ready=%b, required 2 1 0100",
               m_axis_tid, busy, s_axis_tready);
    end
    step();
    step();
    step();
    n_tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_release: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int bad;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < N; k++) add_pkt(k, 2);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (busy !== (i % 3 != 0)) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rr_bubble: got %0d cycles off the busy pattern, required 0", bad);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_complete: got %0d beats pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    add_pkt(1, 4);
    step();
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = pat[i];
      step();
      n_tests++;
      if (s_axis_tready !== {2'b00, pat[i], 1'b0}) begin
        n_fail++;
        $display("FAIL bp_ready_mirror: cycle %0d got ready=%b, required %b",
                 i, s_axis_tready, {2'b00, pat[i], 1'b0});
      end
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_hold_grant();
    int bad;
    do_reset();
    add_pkt(3, 4);
    step();
    step();
    add_pkt(0, 2);
    src_hold[3] = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (m_axis_tid !== 2'd3 || busy !== 1'b1 || m_axis_tvalid !== 1'b0 || s_axis_tready[0] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_grant: got %0d cycles not held on source 3, required 0", bad);
    end
    src_hold[3] = 1'b0;
    drain(40);
  endtask

  task automatic test_async_reset();
    do_reset();
    add_pkt(2, 4);
    step();
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b ready=%b busy=%b, required 0 0000 0",
               m_axis_tvalid, s_axis_tready, busy);
    end
    clear_all();
    @(negedge clk);
    resetn = 1'b1;
    add_pkt(0, 2);
    add_pkt(3, 2);
    drain(40);
  endtask

`ifdef AXIS_PKT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int p = 0; p < 5; p++) add_pkt(1, 2);
    for (int p = 0; p < 5; p++) begin
      m_axis_tready = 1'b0;
      repeat (5) step();
      m_axis_tready = 1'b1;
      repeat (2) step();
    end
    step();
    n_tests++;
    if (pkt_count[1*32 +: 32] !== 32'd5 || pkt_count[0*32 +: 32] !== 32'd0 ||
        pkt_count[2*32 +: 32] !== 32'd0 || pkt_count[3*32 +: 32] !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_pkt_count: got %h, required source1=5 others 0", pkt_count);
    end
    n_tests++;
    if (stall_count !== 32'd20) begin
      n_fail++;
      $display("FAIL stats_stall_count: got %0d, required 20", stall_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_hold_grant();
    test_async_reset();
`ifdef AXIS_PKT_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
